// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator collector: FSM state encoding
// and the digit-pair to shift-amount mapping used by the combine stage.
package acc_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    COMB = 2'd1,
    OUT  = 2'd2
  } acc_state_t;

  // Partial sum k belongs to activation digit k/w_w and weight digit k%w_w.
  // Its binary weight is the sum of the two digit positions.
  function automatic int shift_weight(input int k, input int w_w);
    return (k / w_w) + (k % w_w);
  endfunction

endpackage

// File: rtl/acc_combine.sv
// Shift-and-add accumulator: folds one sign-extended partial sum per enabled
// cycle into a wrapping two's-complement running total.
module acc_combine #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int SH_W   = 3
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] entry,
  input  logic        [SH_W-1:0]   shift,
  output logic signed [RES_W-1:0]  acc
);

  logic signed [RES_W-1:0] entry_ext;
  logic signed [RES_W-1:0] term;

  assign entry_ext = {{(RES_W-DATA_W){entry[DATA_W-1]}}, entry};
  assign term      = entry_ext <<< shift;

  // Clear has priority so a new window (or reset) always starts from zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/acc_collector.sv
// Collects A_W*W_W digit-pair partial sums from the last PE, then combines
// them serially into one signed binary window result with a valid/ready
// handshake on the output.
module acc_collector
  import acc_pkg::*;
#(
  parameter int A_W        = 3,
  parameter int W_W        = 3,
  parameter int ACC_ADDR_W = $clog2(A_W*W_W),
  parameter int ACC_DATA_W = 8,
  parameter int RES_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         acc_done,
  input  logic                         acc_valid,
  input  logic        [ACC_ADDR_W-1:0] acc_addr,
  input  logic signed [ACC_DATA_W-1:0] acc_data,
  output logic signed [RES_W-1:0]      result,
  output logic                         result_valid,
  input  logic                         result_ready
);

  localparam int N     = A_W * W_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = ((A_W + W_W - 1) > 1) ? $clog2(A_W + W_W - 1) : 1;

  localparam logic [ACC_ADDR_W:0] N_ADDR   = (ACC_ADDR_W + 1)'(N);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(N - 1);
  localparam logic [K_W-1:0]      LAST_K   = K_W'(N - 1);

  acc_state_t                  state;
  logic        [CNT_W-1:0]     cnt;
  logic        [K_W-1:0]       k;
  logic signed [ACC_DATA_W-1:0] entry_mem [N];

  logic                        addr_ok;
  logic                        beat_ok;
  logic                        last_beat;
  logic        [SH_W-1:0]      shift;
  logic                        comb_clear;
  logic                        comb_en;
  logic signed [RES_W-1:0]     acc;

  assign addr_ok    = ({1'b0, acc_addr} < N_ADDR);
  assign beat_ok    = (state == RECV) && acc_valid && addr_ok;
  assign last_beat  = beat_ok && (cnt == LAST_CNT);
  assign shift      = SH_W'(shift_weight(int'(k), W_W));
  assign comb_clear = !rst || last_beat;
  assign comb_en    = (state == COMB);
  assign result     = acc;

  // Partial-sum buffer: written by accepted beats only, never reset.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      entry_mem[acc_addr] <= acc_data;
    end
  end

  // Window control: receive beats, step the combine index, hold the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RECV;
      cnt          <= '0;
      k            <= '0;
      acc_done     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          acc_done <= 1'b1;
          if (beat_ok) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state    <= COMB;
              k        <= '0;
              acc_done <= 1'b0;
            end
          end
        end
        COMB: begin
          k <= k + 1'b1;
          if (k == LAST_K) begin
            state        <= OUT;
            result_valid <= 1'b1;
          end
        end
        OUT: begin
          if (result_ready) begin
            state        <= RECV;
            cnt          <= '0;
            result_valid <= 1'b0;
            acc_done     <= 1'b1;
          end
        end
        default: begin
          state        <= RECV;
          cnt          <= '0;
          k            <= '0;
          acc_done     <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  acc_combine #(
    .DATA_W(ACC_DATA_W),
    .RES_W (RES_W),
    .SH_W  (SH_W)
  ) u_combine (
    .clk   (clk),
    .clear (comb_clear),
    .enable(comb_en),
    .entry (entry_mem[k]),
    .shift (shift),
    .acc   (acc)
  );

endmodule

// File: tb/tb_acc_collector.sv
// Directed bench for acc_collector with A_W=W_W=3, ACC_DATA_W=8, RES_W=16.
module tb_acc_collector;

  logic              clk;
  logic              rst;
  logic              acc_done;
  logic              acc_valid;
  logic        [3:0] acc_addr;
  logic signed [7:0] acc_data;
  logic signed [15:0] result;
  logic              result_valid;
  logic              result_ready;

  int errors = 0;
  int checks = 0;

  acc_collector #(
    .A_W       (3),
    .W_W       (3),
    .ACC_ADDR_W(4),
    .ACC_DATA_W(8),
    .RES_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .acc_done    (acc_done),
    .acc_valid   (acc_valid),
    .acc_addr    (acc_addr),
    .acc_data    (acc_data),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int a, input int d);
    acc_valid = 1'b1;
    acc_addr  = 4'(a);
    acc_data  = 8'(d);
    tick();
    acc_valid = 1'b0;
  endtask

  // Send nine beats; optionally reversed order and with out-of-range beats
  // interleaved. With noisy set, acc_valid stays high during COMB on addr 8.
  task automatic send_window(input int v[9], input bit rev, input bit noisy);
    check("acc_done_recv", int'(acc_done), 1);
    for (int idx = 0; idx < 9; idx++) begin
      if (noisy) send_beat(9 + (idx % 7), 77);
      send_beat(rev ? 8 - idx : idx, v[rev ? 8 - idx : idx]);
    end
    if (noisy) begin
      acc_valid = 1'b1;
      acc_addr  = 4'd8;
      acc_data  = 8'sd50;
    end
  endtask

  // Wait for result_valid (bounded), checking latency, acc_done and value.
  task automatic wait_result(input string tag, input int exp);
    int n;
    bit done_seen;
    n = 0;
    done_seen = 1'b0;
    while (!result_valid && n < 20) begin
      if (acc_done) done_seen = 1'b1;
      tick();
      n++;
    end
    acc_valid = 1'b0;
    check({tag, "_latency"}, n, 9);
    check({tag, "_done_low_comb"}, int'(done_seen), 0);
    check({tag, "_result"}, int'(result), exp);
    check({tag, "_done_low_out"}, int'(acc_done), 0);
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(result_valid), 0);
    check({tag, "_done_back"}, int'(acc_done), 1);
  endtask

  initial begin
    int ones[9];
    int v[9];
    rst          = 1'b0;
    acc_valid    = 1'b0;
    acc_addr     = '0;
    acc_data     = '0;
    result_ready = 1'b0;
    foreach (ones[i]) ones[i] = 1;

    // Reset state
    tick();
    tick();
    check("rst_valid", int'(result_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_done", int'(acc_done), 0);
    rst = 1'b1;
    tick();
    check("post_rst_done", int'(acc_done), 1);
    check("post_rst_valid", int'(result_valid), 0);

    // All ones: (1+2+4)^2 = 49, plus a 5-cycle hold in OUT
    send_window(ones, 1'b0, 1'b0);
    wait_result("ones", 49);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_result", int'(result), 49);
      check("hold_valid", int'(result_valid), 1);
    end
    release_result("ones");

    // Entry 0 = -1 -> 0xFFFF
    foreach (v[i]) v[i] = 0;
    v[0] = -1;
    send_window(v, 1'b0, 1'b0);
    wait_result("neg1", -1);
    release_result("neg1");

    // Entry 8 = 127, sent in reverse order -> 127 << 4 = 2032
    foreach (v[i]) v[i] = 0;
    v[8] = 127;
    send_window(v, 1'b1, 1'b0);
    wait_result("e8max", 2032);
    release_result("e8max");

    // All -128 -> -128 * 49 = -6272
    foreach (v[i]) v[i] = -128;
    send_window(v, 1'b0, 1'b0);
    wait_result("allmin", -6272);
    release_result("allmin");

    // All ones with out-of-range beats and acc_valid held during COMB
    send_window(ones, 1'b0, 1'b1);
    wait_result("noisy", 49);
    release_result("noisy");

    // Reset in the middle of COMB discards the window
    foreach (v[i]) v[i] = 0;
    v[4] = 3;
    send_window(v, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("midrst_valid", int'(result_valid), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_done", int'(acc_done), 0);
    rst = 1'b1;
    tick();
    check("midrst_done_back", int'(acc_done), 1);

    // Next window after reset: entry 4 = 3 -> 3 << 2 = 12
    send_window(v, 1'b0, 1'b0);
    wait_result("after_rst", 12);
    release_result("after_rst");

    // Repeated address overwrites and counts: addr0 = 5 then 1, addrs 1..7 = 0;
    // entry 8 is left from the previous window (0), so result = 1
    check("rep_done", int'(acc_done), 1);
    send_beat(0, 5);
    send_beat(0, 1);
    for (int a = 1; a < 8; a++) send_beat(a, 0);
    wait_result("repeat", 1);
    release_result("repeat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_collector.md
ACC_COLLECTOR -- requirements
Module: acc_collector

Interface
REQ-001 SHALL have parameter A_W, default 3: activation digit count.
REQ-002 SHALL have parameter W_W, default 3: weight digit count.
REQ-003 SHALL have parameter ACC_ADDR_W, default $clog2(A_W*W_W): accumulator address width.
REQ-004 SHALL have parameter ACC_DATA_W, default 8: signed partial-sum width.
REQ-005 SHALL have parameter RES_W, default 16: signed result width.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port acc_done, output, 1: collector can accept beats (drives last PE acc_done_in).
REQ-009 SHALL have port acc_valid, input, 1: beat valid from last PE.
REQ-010 SHALL have port acc_addr, input, ACC_ADDR_W: beat address, addr = i*W_W + j (i activation digit, j weight digit).
REQ-011 SHALL have port acc_data, input, ACC_DATA_W: signed partial sum for acc_addr.
REQ-012 SHALL have port result, output, RES_W: signed binary window result.
REQ-013 SHALL have port result_valid, output, 1: result valid.
REQ-014 SHALL have port result_ready, input, 1: consumer accepts result.

Function
REQ-015 SHALL implement FSM states RECV, COMB, OUT; reset state RECV.
REQ-016 SHALL drive acc_done = 1 only in RECV.
REQ-017 In RECV, each cycle with acc_valid=1 and acc_addr < A_W*W_W SHALL store acc_data into a local buffer entry acc_addr and increment beat counter.
REQ-018 Beats with acc_addr >= A_W*W_W SHALL be dropped without storing or counting.
REQ-019 A repeated address SHALL overwrite the entry and still count.
REQ-020 On the edge storing beat number A_W*W_W, the FSM SHALL go to COMB with combine index k=0 and accumulator cleared.
REQ-021 acc_valid outside RECV SHALL be ignored.
REQ-022 In COMB, each cycle SHALL add sign_extend(buf[k]) << (k/W_W + k%W_W) to the RES_W accumulator, k incrementing by 1.
REQ-023 Digit 0 SHALL be least significant, radix 2; arithmetic two's-complement, wrapping modulo 2^RES_W.
REQ-024 After k = A_W*W_W-1 is added, FSM SHALL go to OUT; result_valid rises exactly A_W*W_W cycles after the last-beat edge.
REQ-025 In OUT, result and result_valid SHALL hold stable until result_ready=1; on that edge go to RECV, beat counter cleared.
REQ-026 result_valid SHALL be 0 in RECV and COMB.

Reset
REQ-027 rst=0 SHALL force state RECV, beat counter 0, k 0, accumulator 0, result 0, result_valid 0, acc_done 0 during reset cycle then 1.
REQ-028 Reset in any state, including mid-COMB or OUT, SHALL discard the partial window.
REQ-029 Buffer contents SHALL need no reset.

Structure
REQ-030 FSM state enum and the shift-weight function (k -> k/W_W + k%W_W) SHALL live in shared package acc_pkg.
REQ-031 Shift-and-add datapath SHALL be sub-module acc_combine (inputs buf entry, shift, clear, enable; output accumulator).

Verification (A_W=W_W=3, ACC_DATA_W=8, RES_W=16)
REQ-032 All 9 entries = 1, addresses 0..8 back-to-back -> result = 49, result_valid 9 cycles after last beat.
REQ-033 Entry 0 = -1, others 0 -> result = 0xFFFF (-1).
REQ-034 Entry 8 = 127, others 0, addresses sent 8..0 -> result = 2032; all entries = -128 -> result = -6272.
REQ-035 Beats with addr 9..15 interleaved -> ignored, result unchanged vs. clean run; acc_done low throughout COMB/OUT.
REQ-036 result_ready held low 5 cycles in OUT -> result, result_valid stable; rst=0 mid-COMB -> result_valid 0, next window correct.
